// File: rtl/cbd_ctrl_pkg.sv
// cbd_ctrl_pkg: shared widths, legality limits, state encoding and helpers for the cbd noise sequencer
package cbd_ctrl_pkg;
    localparam int KYBER_N = 256;
    localparam int DATA_W = 64;
    localparam int COEF_W = 48;
    localparam int ADDR_W = 7;
    localparam logic [2:0] K_MIN = 3'd2;
    localparam logic [2:0] K_MAX = 3'd4;
    localparam logic [1:0] ETA_MIN = 2'd2;
    localparam logic [1:0] ETA_MAX = 2'd3;
    localparam logic [4:0] COEF_BEATS = 5'd16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    function automatic logic [4:0] prf_beats(input logic [1:0] eta);
        return {eta, 3'b000};
    endfunction

    function automatic logic cfg_legal(input logic [2:0] k, input logic [1:0] eta1, input logic [1:0] eta2);
        return k >= K_MIN && k <= K_MAX && eta1 >= ETA_MIN && eta1 <= ETA_MAX && eta2 >= ETA_MIN && eta2 <= ETA_MAX;
    endfunction
endpackage

// File: rtl/cbd_ctrl_if.sv
// cbd_ctrl_if: config, PRF, cbd and poly-RAM signals of the noise sequencer
interface cbd_ctrl_if;
    import cbd_ctrl_pkg::*;
    logic              start;
    logic [2:0]        k;
    logic [1:0]        eta1;
    logic [1:0]        eta2;
    logic [7:0]        nonce_base;
    logic              busy;
    logic              done;
    logic              err;
    logic              prf_req;
    logic [7:0]        prf_nonce;
    logic [4:0]        prf_len;
    logic [DATA_W-1:0] prf_data;
    logic              prf_valid;
    logic              prf_ready;
    logic [DATA_W-1:0] cbd_ibytes;
    logic              cbd_ibytes_valid;
    logic [1:0]        cbd_eta;
    logic              cbd_ibytes_ready;
    logic [COEF_W-1:0] cbd_coeffs;
    logic              cbd_coeffs_valid;
    logic              cbd_done;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [COEF_W-1:0] mem_wdata;

    modport master (
        input  start, k, eta1, eta2, nonce_base, prf_data, prf_valid,
               cbd_ibytes_ready, cbd_coeffs, cbd_coeffs_valid, cbd_done,
        output busy, done, err, prf_req, prf_nonce, prf_len, prf_ready,
               cbd_ibytes, cbd_ibytes_valid, cbd_eta, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output start, k, eta1, eta2, nonce_base, prf_data, prf_valid,
               cbd_ibytes_ready, cbd_coeffs, cbd_coeffs_valid, cbd_done,
        input  busy, done, err, prf_req, prf_nonce, prf_len, prf_ready,
               cbd_ibytes, cbd_ibytes_valid, cbd_eta, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cbd_ctrl.sv
// cbd_ctrl: issues one PRF stream per noise polynomial (k at eta1, k at eta2),
// forwards it into cbd and writes the coefficient beats contiguously to poly RAM.
module cbd_ctrl
    import cbd_ctrl_pkg::*;
(
    input logic        clk,
    input logic        rst_n,
    cbd_ctrl_if.master bus
);
    state_t     state;
    logic [2:0] k_q;
    logic [2:0] poly_idx;
    logic [1:0] eta1_q;
    logic [1:0] eta2_q;
    logic [7:0] base_q;
    logic [4:0] in_cnt;
    logic [4:0] out_cnt;
    logic       done_seen;
    logic       in_open;
    logic       xfer;
    logic [4:0] out_next;
    logic       poly_ok;
    logic       last;
    logic [2:0] next_idx;
    logic [1:0] next_eta;

    always_comb begin
        in_open              = state == S_STREAM && in_cnt < bus.prf_len;
        bus.cbd_ibytes       = state == S_STREAM ? bus.prf_data : '0;
        bus.cbd_ibytes_valid = in_open & bus.prf_valid;
        bus.prf_ready        = in_open & bus.cbd_ibytes_ready;
        xfer                 = bus.cbd_ibytes_valid & bus.cbd_ibytes_ready;
        bus.mem_we           = state != S_IDLE && bus.cbd_coeffs_valid && out_cnt < COEF_BEATS;
        bus.mem_addr         = bus.mem_we ? {poly_idx, out_cnt[3:0]} : '0;
        bus.mem_wdata        = bus.mem_we ? bus.cbd_coeffs : '0;
        out_next             = out_cnt + 5'(bus.mem_we);
        // cbd may finish on the same cycle as its 16th beat, or earlier than DRAIN
        poly_ok              = (done_seen | bus.cbd_done) && out_next == COEF_BEATS;
        last                 = {1'b0, poly_idx} == {k_q, 1'b0} - 4'd1;
        next_idx             = poly_idx + 3'd1;
        next_eta             = next_idx < k_q ? eta1_q : eta2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            k_q           <= '0;
            poly_idx      <= '0;
            eta1_q        <= '0;
            eta2_q        <= '0;
            base_q        <= '0;
            in_cnt        <= '0;
            out_cnt       <= '0;
            done_seen     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.prf_req   <= 1'b0;
            bus.prf_nonce <= '0;
            bus.prf_len   <= '0;
            bus.cbd_eta   <= '0;
        end else begin
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
            bus.prf_req <= 1'b0;
            out_cnt     <= (state == S_REQ ? 5'd0 : out_cnt) + 5'(bus.mem_we);
            case (state)
                S_IDLE: if (bus.start) begin
                    if (cfg_legal(bus.k, bus.eta1, bus.eta2)) begin
                        k_q           <= bus.k;
                        eta1_q        <= bus.eta1;
                        eta2_q        <= bus.eta2;
                        base_q        <= bus.nonce_base;
                        poly_idx      <= '0;
                        in_cnt        <= '0;
                        out_cnt       <= '0;
                        bus.busy      <= 1'b1;
                        bus.prf_req   <= 1'b1;
                        bus.prf_nonce <= bus.nonce_base;
                        bus.prf_len   <= prf_beats(bus.eta1);
                        bus.cbd_eta   <= bus.eta1;
                        state         <= S_REQ;
                    end else begin
                        bus.err <= 1'b1;
                    end
                end
                S_REQ: begin
                    in_cnt    <= '0;
                    done_seen <= 1'b0;
                    state     <= S_STREAM;
                end
                S_STREAM: begin
                    in_cnt    <= in_cnt + 5'(xfer);
                    done_seen <= done_seen | bus.cbd_done;
                    if (in_cnt == bus.prf_len) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    done_seen <= done_seen | bus.cbd_done;
                    if (poly_ok && last) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= S_FIN;
                    end else if (poly_ok) begin
                        poly_idx      <= next_idx;
                        bus.prf_req   <= 1'b1;
                        bus.prf_nonce <= base_q + {5'd0, next_idx};
                        bus.prf_len   <= prf_beats(next_eta);
                        bus.cbd_eta   <= next_eta;
                        state         <= S_REQ;
                    end
                end
                S_FIN: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cbd_ctrl.sv
// tb_cbd_ctrl: directed passes with PRF/cbd behavioural models; request and write scoreboards
module tb_cbd_ctrl;
    import cbd_ctrl_pkg::*;

    typedef struct {logic [7:0] nonce; logic [4:0] len;} req_t;
    typedef struct {logic [ADDR_W-1:0] addr; logic [COEF_W-1:0] data;} wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cbd_ctrl_if bus();
    cbd_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    int checks = 0;
    int errors = 0;
    req_t req_q[$];
    wr_t  wr_q[$];
    int   req_cnt, wr_cnt, done_cnt, err_cnt, busy_bad;
    bit   running, rnd, prf_on, emit;
    logic [7:0] prf_nonce, m_base;
    logic [4:0] prf_len, prf_beat;
    int   cpoly, cin, cout;

    function automatic logic [63:0] prf_gold(input logic [7:0] n, input logic [4:0] b);
        return {n, 3'b000, b, 16'hC0DE, n ^ {3'b000, b}, 24'h5A5A5A};
    endfunction

    function automatic logic [47:0] coef_gold(input logic [2:0] p, input logic [3:0] b);
        return {5'd0, p, 4'd0, b, 16'h3C3C ^ {p, b, 9'h01F}, 16'hA000 | {9'd0, p, b}};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, 64'(|{bus.busy, bus.done, bus.err, bus.prf_req, bus.prf_nonce, bus.prf_len,
                       bus.prf_ready, bus.cbd_ibytes, bus.cbd_ibytes_valid, bus.cbd_eta,
                       bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'd0);
    endtask

    task automatic model_clear();
        req_q.delete();
        wr_q.delete();
        req_cnt = 0; wr_cnt = 0; done_cnt = 0; err_cnt = 0; busy_bad = 0;
        running = 0; prf_on = 0; emit = 0;
        prf_beat = '0; prf_len = '0; prf_nonce = '0;
        cpoly = 0; cin = 0; cout = 0;
    endtask

    task automatic observe();
        req_t r;
        wr_t  w;
        if (bus.prf_req) begin
            req_cnt++;
            chk("req_pending", 64'(req_q.size() > 0), 64'd1);
            if (req_q.size() > 0) begin
                r = req_q.pop_front();
                chk("prf_nonce", 64'(bus.prf_nonce), 64'(r.nonce));
                chk("prf_len", 64'(bus.prf_len), 64'(r.len));
            end
            prf_on = 1; prf_nonce = bus.prf_nonce; prf_len = bus.prf_len; prf_beat = '0;
        end
        if (bus.prf_valid && bus.prf_ready) prf_beat++;
        if (bus.cbd_ibytes_valid && bus.cbd_ibytes_ready) begin
            chk("fwd_extra", 64'(emit), 64'd0);
            chk("fwd_data", bus.cbd_ibytes, prf_gold(8'(m_base + 8'(cpoly)), 5'(cin)));
            cin++;
            if (cin == 8 * int'(bus.cbd_eta)) begin
                emit = 1;
                cout = 0;
            end
        end
        if (bus.cbd_coeffs_valid) cout++;
        if (bus.cbd_done) begin
            emit = 0; cin = 0; cpoly++;
        end
        if (bus.mem_we) begin
            wr_cnt++;
            chk("wr_pending", 64'(wr_q.size() > 0), 64'd1);
            if (wr_q.size() > 0) begin
                w = wr_q.pop_front();
                chk("mem_addr", 64'(bus.mem_addr), 64'(w.addr));
                chk("mem_wdata", 64'(bus.mem_wdata), 64'(w.data));
            end
        end
        if (bus.err) err_cnt++;
        if (running && !bus.done && !bus.busy) busy_bad++;
        if (bus.done) begin
            done_cnt++;
            running = 0;
        end
    endtask

    task automatic drive();
        bus.prf_data = prf_gold(prf_nonce, prf_beat);
        bus.cbd_coeffs = coef_gold(3'(cpoly), 4'(cout));
        if (!rst_n) begin
            bus.prf_valid = 0; bus.cbd_ibytes_ready = 0; bus.cbd_coeffs_valid = 0; bus.cbd_done = 0;
            return;
        end
        bus.prf_valid = prf_on && prf_beat < prf_len && (!rnd || $urandom_range(1) == 1);
        bus.cbd_ibytes_ready = !emit && (!rnd || $urandom_range(1) == 1);
        bus.cbd_coeffs_valid = emit && cout < 16 && (!rnd || $urandom_range(1) == 1);
        bus.cbd_done = emit && ((cpoly % 2 == 1) ? (cout == 15 && bus.cbd_coeffs_valid) : cout == 16);
    endtask

    initial begin : models
        forever begin
            @(negedge clk);
            if (rst_n) observe();
            @(posedge clk);
            #1;
            drive();
        end
    end

    task automatic start_pass(input int k, input int e1, input int e2, input logic [7:0] base);
        bus.k = 3'(k); bus.eta1 = 2'(e1); bus.eta2 = 2'(e2); bus.nonce_base = base;
        @(posedge clk); #1 bus.start = 1;
        @(posedge clk); #1 bus.start = 0;
    endtask

    task automatic launch(input int k, input int e1, input int e2, input logic [7:0] base, input bit r);
        model_clear();
        rnd = r;
        m_base = base;
        for (int p = 0; p < 2 * k; p++) begin
            req_q.push_back('{8'(base + 8'(p)), 5'(8 * (p < k ? e1 : e2))});
            for (int b = 0; b < 16; b++) wr_q.push_back('{7'(p * 16 + b), coef_gold(3'(p), 4'(b))});
        end
        start_pass(k, e1, e2, base);
        running = 1;
    endtask

    task automatic finish_pass(input int k);
        for (int i = 0; i < 6000 && done_cnt == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("write_count", 64'(wr_cnt), 64'(32 * k));
        chk("req_count", 64'(req_cnt), 64'(2 * k));
        chk("req_left", 64'(req_q.size()), 64'd0);
        chk("wr_left", 64'(wr_q.size()), 64'd0);
        chk("busy_drop", 64'(busy_bad), 64'd0);
        chk("busy_after", 64'(bus.busy), 64'd0);
        chk("err_in_pass", 64'(err_cnt), 64'd0);
    endtask

    task automatic illegal(input int k, input int e1, input int e2);
        model_clear();
        start_pass(k, e1, e2, 8'h33);
        repeat (3) @(posedge clk);
        #1;
        chk("err_pulses", 64'(err_cnt), 64'd1);
        chk("err_no_req", 64'(req_cnt), 64'd0);
        chk("err_busy", 64'(bus.busy), 64'd0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bus.start = 0; bus.k = '0; bus.eta1 = '0; bus.eta2 = '0; bus.nonce_base = '0;
        bus.prf_data = '0; bus.prf_valid = 0; bus.cbd_ibytes_ready = 0;
        bus.cbd_coeffs = '0; bus.cbd_coeffs_valid = 0; bus.cbd_done = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #2 chk_zero("reset_outputs");
        #1 rst_n = 1;
        launch(2, 3, 2, 8'h00, 0);
        finish_pass(2);
        launch(3, 2, 2, 8'h40, 1);
        finish_pass(3);
        launch(2, 2, 2, 8'hFE, 0);
        finish_pass(2);
        illegal(5, 2, 2);
        illegal(2, 1, 2);
        launch(2, 2, 3, 8'h10, 0);
        finish_pass(2);
        launch(2, 3, 3, 8'h20, 0);
        for (int i = 0; i < 2000 && req_cnt < 2; i++) @(posedge clk);
        start_pass(4, 2, 2, 8'h99);
        finish_pass(2);
        launch(2, 3, 2, 8'h00, 0);
        for (int i = 0; i < 2000 && !(cpoly == 1 && cin >= 10); i++) @(posedge clk);
        chk("reached_beat10", 64'(cpoly == 1 && cin >= 10), 64'd1);
        #3 rst_n = 0;
        model_clear();
        #1 chk_zero("async_reset");
        @(posedge clk);
        #3 rst_n = 1;
        launch(4, 3, 2, 8'h80, 0);
        finish_pass(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
